// File: rtl/vm2413_eg_multi_if.sv
// Bus bundle for the time-multiplexed VM2413 envelope generator.
//
// Groups the slot-advance strobe, the per-slot configuration write port and
// the registered per-slot result port.
//   clkena    : advance the engine by one slot
//   cfg_we    : write cfg_* into slot cfg_slot (slots >= SLOTS are ignored)
//   cfg_ar/dr/sl/rr, cfg_eg, cfg_key : configuration fields
//   out_valid : one-cycle pulse per processed slot
//   out_slot  : slot just processed
//   out_att   : attenuation, all-ones = silent
//   out_state : Finish=0 Attack=1 Decay=2 Sustain=3 Release=4
// master drives clkena/cfg and observes results; slave is the engine.
interface vm2413_eg_multi_if #(
  parameter int ATT_W = 7
);
  logic             clkena;
  logic             cfg_we;
  logic [4:0]       cfg_slot;
  logic [3:0]       cfg_ar;
  logic [3:0]       cfg_dr;
  logic [3:0]       cfg_sl;
  logic [3:0]       cfg_rr;
  logic             cfg_eg;
  logic             cfg_key;
  logic             out_valid;
  logic [4:0]       out_slot;
  logic [ATT_W-1:0] out_att;
  logic [2:0]       out_state;

  modport master (
    output clkena, cfg_we, cfg_slot, cfg_ar, cfg_dr, cfg_sl, cfg_rr,
           cfg_eg, cfg_key,
    input  out_valid, out_slot, out_att, out_state
  );

  modport slave (
    input  clkena, cfg_we, cfg_slot, cfg_ar, cfg_dr, cfg_sl, cfg_rr,
           cfg_eg, cfg_key,
    output out_valid, out_slot, out_att, out_state
  );
endinterface

// File: rtl/vm2413_eg_multi.sv
// Time-multiplexed envelope generator for the VM2413 FM core.
//
// One update engine serves SLOTS operator slots round-robin. Each slot keeps
// its own configuration, key history, envelope state and PHASE_W-bit phase
// accumulator. Every clkena pulse processes the slot under the internal
// counter and presents the new attenuation/state one cycle later.
//
// Ports
//   clk    : core clock
//   reset  : asynchronous, active-high; all slots back to Finish/silent
//   bus    : vm2413_eg_multi_if slave (clkena, cfg write port, result port)
//
// Envelope: Finish(0) -> Attack(1) -> Decay(2) -> Sustain(3) -> Release(4)
// -> Finish. Phase 0 is full volume, all-ones is silence; the attenuation
// output is the top ATT_W bits of the phase.
module vm2413_eg_multi #(
  parameter int SLOTS   = 18,
  parameter int PHASE_W = 23,
  parameter int ATT_W   = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  vm2413_eg_multi_if.slave        bus
);

  typedef enum logic [2:0] {
    ST_FINISH  = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } eg_state_t;

  localparam logic [PHASE_W-1:0] PH_MAX    = {PHASE_W{1'b1}};
  localparam logic [4:0]         LAST_SLOT = 5'(SLOTS - 1);

  // Per-slot storage
  logic [3:0]         ar_q  [SLOTS];
  logic [3:0]         dr_q  [SLOTS];
  logic [3:0]         sl_q  [SLOTS];
  logic [3:0]         rr_q  [SLOTS];
  logic               eg_q  [SLOTS];
  logic               key_q [SLOTS];
  logic               kp_q  [SLOTS];
  eg_state_t          st_q  [SLOTS];
  logic [PHASE_W-1:0] ph_q  [SLOTS];

  logic [4:0]         s_q;

  // Rate to per-visit phase step. Rates 1..14 double per step; rate 15 is
  // one extra doubling above rate 14.
  function automatic logic [PHASE_W-1:0] inc(input logic [3:0] r);
    logic [PHASE_W-1:0] one;
    one = {{(PHASE_W-1){1'b0}}, 1'b1};
    if (r == 4'd0)
      return '0;
    else if (r == 4'd15)
      return one << (PHASE_W - 5);
    else
      return one << (32'(r) + PHASE_W - 20);
  endfunction

  function automatic logic [PHASE_W-1:0] sat_add(input logic [PHASE_W-1:0] a,
                                                 input logic [PHASE_W-1:0] b);
    logic [PHASE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[PHASE_W] ? PH_MAX : sum[PHASE_W-1:0];
  endfunction

  function automatic logic [PHASE_W-1:0] sat_sub(input logic [PHASE_W-1:0] a,
                                                 input logic [PHASE_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

  // Update of the slot under the counter
  logic               hit;
  logic [3:0]         ar_e, dr_e, sl_e, rr_e;
  logic               eg_e, key_e, kp_c;
  eg_state_t          st_c, st_k, st_n;
  logic [PHASE_W-1:0] ph_c, ph_n;
  logic [ATT_W-1:0]   thr;

  always_comb begin
    // A configuration write aimed at the slot being processed this cycle
    // is seen by this update, key included.
    hit   = bus.cfg_we && (bus.cfg_slot == s_q);
    ar_e  = hit ? bus.cfg_ar  : ar_q[s_q];
    dr_e  = hit ? bus.cfg_dr  : dr_q[s_q];
    sl_e  = hit ? bus.cfg_sl  : sl_q[s_q];
    rr_e  = hit ? bus.cfg_rr  : rr_q[s_q];
    eg_e  = hit ? bus.cfg_eg  : eg_q[s_q];
    key_e = hit ? bus.cfg_key : key_q[s_q];
    kp_c  = kp_q[s_q];
    st_c  = st_q[s_q];
    ph_c  = ph_q[s_q];
    thr   = {sl_e, {(ATT_W-4){1'b0}}};

    // Key edges take priority; the resulting state is then run this visit.
    st_k = st_c;
    if (key_e && !kp_c)
      st_k = ST_ATTACK;
    else if (!key_e && kp_c && (st_c != ST_FINISH))
      st_k = ST_RELEASE;

    st_n = st_k;
    ph_n = ph_c;
    case (st_k)
      ST_ATTACK: begin
        ph_n = (ar_e == 4'd15) ? '0 : sat_sub(ph_c, inc(ar_e));
        if (ph_n == '0)
          st_n = ST_DECAY;
      end
      ST_DECAY: begin
        ph_n = sat_add(ph_c, inc(dr_e));
        if (ph_n[PHASE_W-1 -: ATT_W] >= thr)
          st_n = ST_SUSTAIN;
      end
      ST_SUSTAIN: begin
        // Sustained tones hold; percussive tones keep fading at the
        // release rate.
        if (!eg_e) begin
          ph_n = sat_add(ph_c, inc(rr_e));
          if (ph_n == PH_MAX)
            st_n = ST_FINISH;
        end
      end
      ST_RELEASE: begin
        ph_n = sat_add(ph_c, inc(rr_e));
        if (ph_n == PH_MAX)
          st_n = ST_FINISH;
      end
      default: begin
        ph_n = PH_MAX;
        st_n = ST_FINISH;
      end
    endcase
  end

  // Registered slot state and outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SLOTS; i++) begin
        ar_q[i]  <= '0;
        dr_q[i]  <= '0;
        sl_q[i]  <= '0;
        rr_q[i]  <= '0;
        eg_q[i]  <= 1'b0;
        key_q[i] <= 1'b0;
        kp_q[i]  <= 1'b0;
        st_q[i]  <= ST_FINISH;
        ph_q[i]  <= PH_MAX;
      end
      s_q           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_slot  <= '0;
      bus.out_att   <= {ATT_W{1'b1}};
      bus.out_state <= ST_FINISH;
    end else begin
      bus.out_valid <= 1'b0;

      if (bus.cfg_we && (bus.cfg_slot <= LAST_SLOT)) begin
        ar_q[bus.cfg_slot]  <= bus.cfg_ar;
        dr_q[bus.cfg_slot]  <= bus.cfg_dr;
        sl_q[bus.cfg_slot]  <= bus.cfg_sl;
        rr_q[bus.cfg_slot]  <= bus.cfg_rr;
        eg_q[bus.cfg_slot]  <= bus.cfg_eg;
        key_q[bus.cfg_slot] <= bus.cfg_key;
      end

      if (bus.clkena) begin
        st_q[s_q]     <= st_n;
        ph_q[s_q]     <= ph_n;
        kp_q[s_q]     <= key_e;
        s_q           <= (s_q == LAST_SLOT) ? 5'd0 : s_q + 5'd1;
        bus.out_valid <= 1'b1;
        bus.out_slot  <= s_q;
        bus.out_att   <= ph_n[PHASE_W-1 -: ATT_W];
        bus.out_state <= st_n;
      end
    end
  end

endmodule
